// File: rtl/cpu_ad48_dmem_arb.sv
// cpu_ad48_dmem_arb
//
// Shares the single-port cpu_ad48 data memory between the CPU load/store
// unit (port C) and a DMA/debug master (port D). Port C has fixed priority;
// a starvation counter forces a grant to port D after it has been denied
// STARVE_LIMIT consecutive cycles while requesting. One access is accepted
// per cycle. The response (read data, or a plain acknowledge for writes)
// arrives on the owning port exactly one cycle after acceptance.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   c_valid/c_we/c_addr/c_wdata CPU request (held stable until c_ready)
//   c_ready                     CPU request accepted this cycle
//   c_rvalid/c_rdata/c_err      CPU response, one cycle after acceptance
//   d_*                         same set for the DMA/debug port
//   mem_en/mem_we/mem_addr/
//   mem_wdata                   DMEM request strobes and payload
//   mem_rdata                   DMEM read data, valid the cycle after a read
module cpu_ad48_dmem_arb #(
   parameter int DM_WORDS     = 128,
   parameter int AW           = 48,
   parameter int MAW          = 7,
   parameter int STARVE_LIMIT = 4
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           c_valid,
   input  logic           c_we,
   input  logic [AW-1:0]  c_addr,
   input  logic [47:0]    c_wdata,
   output logic           c_ready,
   output logic           c_rvalid,
   output logic [47:0]    c_rdata,
   output logic           c_err,
   input  logic           d_valid,
   input  logic           d_we,
   input  logic [AW-1:0]  d_addr,
   input  logic [47:0]    d_wdata,
   output logic           d_ready,
   output logic           d_rvalid,
   output logic [47:0]    d_rdata,
   output logic           d_err,
   output logic           mem_en,
   output logic           mem_we,
   output logic [MAW-1:0] mem_addr,
   output logic [47:0]    mem_wdata,
   input  logic [47:0]    mem_rdata
);

   localparam logic [3:0]    LIMIT    = 4'(STARVE_LIMIT);
   localparam logic [AW-1:0] ADDR_END = AW'(DM_WORDS);

   typedef enum logic [2:0] {
      TAG_NONE,
      TAG_C_RD,
      TAG_C_WR,
      TAG_D_RD,
      TAG_D_WR
   } tag_t;

   logic [3:0]    starve_cnt_p1;
   tag_t          tag_p1;
   logic          err_p1;

   logic          force_d;
   logic          grant_c;
   logic          grant_d;
   logic          any_grant;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [47:0]   sel_wdata;
   logic          in_range;

   // ---- stage 0: arbitration, range check and memory drive ----
   // Grants are qualified by resetn so nothing is accepted (and no memory
   // strobe escapes) while reset is held, even with requests pending.
   always_comb begin
      force_d   = d_valid & (starve_cnt_p1 == LIMIT);
      grant_d   = resetn & d_valid & (~c_valid | force_d);
      grant_c   = resetn & c_valid & ~grant_d;
      any_grant = grant_c | grant_d;

      sel_we    = grant_d ? d_we    : c_we;
      sel_addr  = grant_d ? d_addr  : c_addr;
      sel_wdata = grant_d ? d_wdata : c_wdata;
      in_range  = sel_addr < ADDR_END;

      mem_en    = any_grant & in_range;
      mem_we    = mem_en & sel_we;
      mem_addr  = mem_en ? sel_addr[MAW-1:0] : '0;
      mem_wdata = mem_en ? sel_wdata : '0;
   end

   assign c_ready = grant_c;
   assign d_ready = grant_d;

   // ---- stage 0 -> 1: starvation counter and response tag ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt_p1 <= '0;
         tag_p1        <= TAG_NONE;
         err_p1        <= 1'b0;
      end else begin
         if (!d_valid || grant_d)
            starve_cnt_p1 <= '0;
         else if (starve_cnt_p1 < LIMIT)
            starve_cnt_p1 <= starve_cnt_p1 + 4'd1;

         if (grant_c)
            tag_p1 <= sel_we ? TAG_C_WR : TAG_C_RD;
         else if (grant_d)
            tag_p1 <= sel_we ? TAG_D_WR : TAG_D_RD;
         else
            tag_p1 <= TAG_NONE;

         err_p1 <= any_grant & ~in_range;
      end
   end

   // ---- stage 1: response steering ----
   // Read data is passed only for an in-range read; writes and range errors
   // return zero so the requester never sees stale memory output.
   always_comb begin
      c_rvalid = (tag_p1 == TAG_C_RD) | (tag_p1 == TAG_C_WR);
      d_rvalid = (tag_p1 == TAG_D_RD) | (tag_p1 == TAG_D_WR);
      c_err    = c_rvalid & err_p1;
      d_err    = d_rvalid & err_p1;
      c_rdata  = ((tag_p1 == TAG_C_RD) && !err_p1) ? mem_rdata : '0;
      d_rdata  = ((tag_p1 == TAG_D_RD) && !err_p1) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_cpu_ad48_dmem_arb.sv
module tb_cpu_ad48_dmem_arb;

   logic        clk = 1'b0;
   logic        resetn;
   logic        c_valid, c_we;
   logic [47:0] c_addr, c_wdata;
   logic        c_ready, c_rvalid, c_err;
   logic [47:0] c_rdata;
   logic        d_valid, d_we;
   logic [47:0] d_addr, d_wdata;
   logic        d_ready, d_rvalid, d_err;
   logic [47:0] d_rdata;
   logic        mem_en, mem_we;
   logic [6:0]  mem_addr;
   logic [47:0] mem_wdata;
   logic [47:0] mem_rdata;

   logic        mem_load;
   logic [47:0] mem [0:127];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_ad48_dmem_arb dut (
      .clk(clk), .resetn(resetn),
      .c_valid(c_valid), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ready(c_ready), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
      .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // DMEM model: MEM[i] = 100*(i+1) after load, so MEM[1]=200, MEM[3]=400.
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 128; i++) mem[i] <= 48'(100 * (i + 1));
         mem_rdata <= '0;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata    <= mem[mem_addr];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   typedef struct {
      logic        cv, cwe;
      logic [47:0] caddr, cwd;
      logic        dv, dwe;
      logic [47:0] daddr, dwd;
      logic        e_cr, e_dr, e_en, e_we;
      logic [6:0]  e_maddr;
      logic        e_crv;
      logic [47:0] e_crd;
      logic        e_cerr, e_drv;
      logic [47:0] e_drd;
      logic        e_derr;
   } vec_t;

   function automatic vec_t mk(
      input logic cv, input logic cwe, input logic [47:0] caddr, input logic [47:0] cwd,
      input logic dv, input logic dwe, input logic [47:0] daddr, input logic [47:0] dwd,
      input logic e_cr, input logic e_dr, input logic e_en, input logic e_we,
      input logic [6:0] e_maddr,
      input logic e_crv, input logic [47:0] e_crd, input logic e_cerr,
      input logic e_drv, input logic [47:0] e_drd, input logic e_derr);
      vec_t v;
      v.cv = cv; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
      v.dv = dv; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
      v.e_cr = e_cr; v.e_dr = e_dr; v.e_en = e_en; v.e_we = e_we;
      v.e_maddr = e_maddr;
      v.e_crv = e_crv; v.e_crd = e_crd; v.e_cerr = e_cerr;
      v.e_drv = e_drv; v.e_drd = e_drd; v.e_derr = e_derr;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      c_valid = v.cv; c_we = v.cwe; c_addr = v.caddr; c_wdata = v.cwd;
      d_valid = v.dv; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwd;
   endtask

   task automatic idle_inputs();
      c_valid = 0; c_we = 0; c_addr = '0; c_wdata = '0;
      d_valid = 0; d_we = 0; d_addr = '0; d_wdata = '0;
   endtask

   // Both ports request continuously from a cleared counter: C,C,C,C,D repeating.
   task automatic contention(input string tag);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         c_valid = 1; c_we = 0; c_addr = 48'd1;
         d_valid = 1; d_we = 0; d_addr = 48'd2;
         #2;
         chk({tag, "_d_ready"}, d_ready, (k % 5) == 4);
         chk({tag, "_c_ready"}, c_ready, (k % 5) != 4);
         chk({tag, "_both_ready"}, c_ready & d_ready, 0);
         @(posedge clk); #1;
         chk({tag, "_rdata"}, (k % 5) == 4 ? d_rdata : c_rdata,
             (k % 5) == 4 ? 48'd300 : 48'd200);
      end
      @(negedge clk);
      idle_inputs();
      @(posedge clk); #1;
   endtask

   vec_t vecs[13];

   initial begin
      // C ld 1; idle; D st 8; D ld 8; C st 4; C ld 4 (read-after-write);
      // C st 128 (out of range); C ld 0 (addr alias untouched); C+D same cycle;
      // idle (counter clears); D ld 200 (out of range); D st 127; C ld 127.
      vecs[0]  = mk(1,0,1,0,        0,0,0,0,         1,0,1,0,1,   1,200,0,   0,0,0);
      vecs[1]  = mk(0,0,0,0,        0,0,0,0,         0,0,0,0,0,   0,0,0,     0,0,0);
      vecs[2]  = mk(0,0,0,0,        1,1,8,67890,     0,1,1,1,8,   0,0,0,     1,0,0);
      vecs[3]  = mk(0,0,0,0,        1,0,8,0,         0,1,1,0,8,   0,0,0,     1,67890,0);
      vecs[4]  = mk(1,1,4,12345,    0,0,0,0,         1,0,1,1,4,   1,0,0,     0,0,0);
      vecs[5]  = mk(1,0,4,0,        0,0,0,0,         1,0,1,0,4,   1,12345,0, 0,0,0);
      vecs[6]  = mk(1,1,128,999,    0,0,0,0,         1,0,0,0,0,   1,0,1,     0,0,0);
      vecs[7]  = mk(1,0,0,0,        0,0,0,0,         1,0,1,0,0,   1,100,0,   0,0,0);
      vecs[8]  = mk(1,0,2,0,        1,0,5,0,         1,0,1,0,2,   1,300,0,   0,0,0);
      vecs[9]  = mk(0,0,0,0,        0,0,0,0,         0,0,0,0,0,   0,0,0,     0,0,0);
      vecs[10] = mk(0,0,0,0,        1,0,200,0,       0,1,0,0,0,   0,0,0,     1,0,1);
      vecs[11] = mk(0,0,0,0,        1,1,127,777,     0,1,1,1,127, 0,0,0,     1,0,0);
      vecs[12] = mk(1,0,127,0,      0,0,0,0,         1,0,1,0,127, 1,777,0,   0,0,0);

      // Reset with both ports requesting: nothing may be granted or strobed.
      resetn = 0; mem_load = 1;
      idle_inputs();
      c_valid = 1; d_valid = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_c_ready", c_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_c_rvalid", c_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_c_rdata", c_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_c_err", c_err, 0);
      chk("rst_d_err", d_err, 0);
      @(negedge clk);
      idle_inputs();
      resetn = 1; mem_load = 0;

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #2;
         chk($sformatf("v%0d_c_ready", i), c_ready, vecs[i].e_cr);
         chk($sformatf("v%0d_d_ready", i), d_ready, vecs[i].e_dr);
         chk($sformatf("v%0d_mem_en", i), mem_en, vecs[i].e_en);
         chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].e_we);
         chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_maddr);
         @(posedge clk); #1;
         chk($sformatf("v%0d_c_rvalid", i), c_rvalid, vecs[i].e_crv);
         chk($sformatf("v%0d_c_rdata", i), c_rdata, vecs[i].e_crd);
         chk($sformatf("v%0d_c_err", i), c_err, vecs[i].e_cerr);
         chk($sformatf("v%0d_d_rvalid", i), d_rvalid, vecs[i].e_drv);
         chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_drd);
         chk($sformatf("v%0d_d_err", i), d_err, vecs[i].e_derr);
      end
      @(negedge clk);
      idle_inputs();
      @(posedge clk); #1;
      chk("mem128_alias_untouched", mem[0], 48'd100);

      contention("cont1");

      // Reset mid-read: accept C read of addr 3, then reset before the response.
      @(negedge clk);
      c_valid = 1; c_we = 0; c_addr = 48'd3;
      d_valid = 1; d_we = 0; d_addr = 48'd2;
      #2;
      chk("mid_c_ready", c_ready, 1);
      chk("mid_mem_addr", mem_addr, 3);
      @(posedge clk); #1;
      resetn = 0;
      #1;
      chk("mid_rst_c_rvalid", c_rvalid, 0);
      chk("mid_rst_c_rdata", c_rdata, 0);
      chk("mid_rst_c_ready", c_ready, 0);
      chk("mid_rst_d_ready", d_ready, 0);
      chk("mid_rst_mem_en", mem_en, 0);
      chk("mid_rst_d_rvalid", d_rvalid, 0);
      @(negedge clk);
      idle_inputs();
      resetn = 1;
      @(posedge clk); #1;
      chk("mid_post_c_rvalid", c_rvalid, 0);
      chk("mid_post_c_rdata", c_rdata, 0);

      // Counter must restart from zero after reset.
      contention("cont2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
